multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-high; forces state FETCH immediately.
REQ-003 SHALL have ports op (input, 7, opcode), funct3 (input, 3), funct7b5 (input, 1, instr[30]), Zero (input, 1, ALU zero flag).
REQ-004 SHALL have outputs PCWrite, MemWrite, IRWrite, RegWrite, AdrSrc (1 each), and ResultSrc, ALUSrcA, ALUSrcB, ImmSrc (2 each).
REQ-005 SHALL have outputs ALUControl (3, ALU operation select), State (4, current state for debug), and Illegal (1, unsupported-opcode pulse).

Function
REQ-006 SHALL implement states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, JAL=10; State output equals the current encoding.
REQ-007 SHALL transition: FETCH->DECODE; DECODE->MEMADR (op 0000011 or 0100011), EXECUTER (0110011), EXECUTEI (0010011), BRANCH (1100011), JAL (1101111), else FETCH.
REQ-008 SHALL transition: MEMADR->MEMREAD (lw) or MEMWRITE (sw); MEMREAD->MEMWB; EXECUTER, EXECUTEI, JAL->ALUWB; MEMWB, MEMWRITE, ALUWB, BRANCH->FETCH.
REQ-009 SHALL assert Illegal for exactly the one DECODE cycle whose op is unsupported; that instruction retires as a no-op.
REQ-010 SHALL drive all state outputs to 0 unless listed in REQ-011..REQ-016.
REQ-011 SHALL drive in FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, PCUpdate=1, ALUOp=00.
REQ-012 SHALL drive in DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00; in MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
REQ-013 SHALL drive in MEMREAD: ResultSrc=00, AdrSrc=1; in MEMWB: ResultSrc=01, RegWrite=1; in MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
REQ-014 SHALL drive in EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10; in EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; in ALUWB: ResultSrc=00, RegWrite=1.
REQ-015 SHALL drive in BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
REQ-016 SHALL drive in JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
REQ-017 SHALL compute PCWrite = PCUpdate | (Branch & taken), with taken = Zero for funct3=000 (beq), ~Zero for 001 (bne), else 0.
REQ-018 SHALL decode ImmSrc combinationally from op in every state: 0100011->01, 1100011->10, 1101111->11, otherwise 00.
REQ-019 SHALL derive ALUControl combinationally: ALUOp 00->000 (add), ALUOp 01->001 (sub).
REQ-020 SHALL derive ALUControl for ALUOp 10 by funct3: 000->001 if op[5]&funct7b5 else 000; 001->111; 010 and 011->101; 100->110; 101->100; 110->011; 111->010.
REQ-021 SHALL hold: ALUOp 11 maps to 000; the ALU encoding is 000 add, 001 sub, 010 and, 011 or, 100 shift-right, 101 set-less-than, 110 xor, 111 shift-left.
REQ-022 SHALL keep every output free of X for any input combination, including unknown funct3 values.

Reset
REQ-023 SHALL, while reset is high, hold State=FETCH; outputs then equal FETCH values: IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10, ALUControl=000, Illegal=0, all others 0 except ImmSrc per REQ-018.
REQ-024 SHALL abandon any in-flight instruction when reset asserts in any state, with no further MemWrite or RegWrite pulse.
REQ-025 SHALL, on the first rising edge after reset deassertion, advance FETCH->DECODE.

Verification
REQ-026 SHALL verify lw (op 0000011): FETCH, DECODE, MEMADR, MEMREAD, MEMWB in 5 cycles, with RegWrite=1 only in MEMWB and ResultSrc=01.
REQ-027 SHALL verify sw (op 0100011): 4 cycles, with MemWrite=1 only in MEMWRITE, ImmSrc=01, and RegWrite never asserted.
REQ-028 SHALL verify R-type sub (funct3 000, funct7b5=1) gives ALUControl=001 in EXECUTER, and I-type addi (op 0010011, funct7b5=1) gives 000.
REQ-029 SHALL verify beq in BRANCH gives PCWrite=1 with Zero=1 and 0 with Zero=0; bne gives the inverse.
REQ-030 SHALL verify op 1111111 produces an Illegal pulse in DECODE, returns to FETCH, and asserts no writes.
REQ-031 SHALL verify reset asserted mid-MEMADR gives State=0 asynchronously and MemWrite=0.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Decode inputs and control outputs between the multicycle controller and its datapath.
// Combinational signals only; no handshake, sampled by the datapath each cycle.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       AdrSrc;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;
  logic       Illegal;

  modport master (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, MemWrite, IRWrite, RegWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, State, Illegal
  );

  modport slave (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, MemWrite, IRWrite, RegWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, State, Illegal
  );
endinterface

// File: rtl/multicycle_controller.sv
// RISC-V multicycle control FSM: Moore state outputs plus combinational ImmSrc/ALUControl/PCWrite.
// One state per cycle (lw 5, sw/branch 3-4, R/I/jal 4); never stalls, no backpressure.
module multicycle_controller (
  input  logic                          clk,
  input  logic                          reset,
  multicycle_controller_if.master       bus
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t     state, state_n;
  logic       pcupdate, branch, taken;
  logic [1:0] aluop;
  logic       memwrite, irwrite, regwrite, adrsrc, illegal;
  logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
  logic [2:0] alucontrol;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    pcupdate  = 1'b0;
    branch    = 1'b0;
    aluop     = 2'b00;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    regwrite  = 1'b0;
    adrsrc    = 1'b0;
    illegal   = 1'b0;
    resultsrc = 2'b00;
    alusrca   = 2'b00;
    alusrcb   = 2'b00;
    case (state)
      FETCH: begin
        irwrite   = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        pcupdate  = 1'b1;
        state_n   = DECODE;
      end
      DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: state_n = MEMADR;
          OP_R:         state_n = EXECUTER;
          OP_I:         state_n = EXECUTEI;
          OP_BR:        state_n = BRANCH;
          OP_JAL:       state_n = JAL;
          default: begin
            // unsupported opcode retires as a no-op
            illegal = 1'b1;
            state_n = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        state_n = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adrsrc  = 1'b1;
        state_n = MEMWB;
      end
      MEMWB: begin
        resultsrc = 2'b01;
        regwrite  = 1'b1;
        state_n   = FETCH;
      end
      MEMWRITE: begin
        adrsrc   = 1'b1;
        memwrite = 1'b1;
        state_n  = FETCH;
      end
      EXECUTER: begin
        alusrca = 2'b10;
        aluop   = 2'b10;
        state_n = ALUWB;
      end
      EXECUTEI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = 2'b10;
        state_n = ALUWB;
      end
      ALUWB: begin
        regwrite = 1'b1;
        state_n  = FETCH;
      end
      BRANCH: begin
        alusrca = 2'b10;
        aluop   = 2'b01;
        branch  = 1'b1;
        state_n = FETCH;
      end
      JAL: begin
        alusrca  = 2'b01;
        alusrcb  = 2'b10;
        pcupdate = 1'b1;
        state_n  = ALUWB;
      end
      default: state_n = FETCH;
    endcase
  end

  always_comb begin
    case (bus.op)
      OP_SW:   immsrc = 2'b01;
      OP_BR:   immsrc = 2'b10;
      OP_JAL:  immsrc = 2'b11;
      default: immsrc = 2'b00;
    endcase
  end

  // subtract only for R-type with funct7[5]; I-type addi ignores instr[30]
  always_comb begin
    case (aluop)
      2'b01: alucontrol = 3'b001;
      2'b10: begin
        case (bus.funct3)
          3'b000:  alucontrol = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
          3'b001:  alucontrol = 3'b111;
          3'b010:  alucontrol = 3'b101;
          3'b011:  alucontrol = 3'b101;
          3'b100:  alucontrol = 3'b110;
          3'b101:  alucontrol = 3'b100;
          3'b110:  alucontrol = 3'b011;
          3'b111:  alucontrol = 3'b010;
          default: alucontrol = 3'b000;
        endcase
      end
      default: alucontrol = 3'b000;
    endcase
  end

  always_comb begin
    case (bus.funct3)
      3'b000:  taken = bus.Zero;
      3'b001:  taken = ~bus.Zero;
      default: taken = 1'b0;
    endcase
  end

  assign bus.PCWrite    = pcupdate | (branch & taken);
  assign bus.MemWrite   = memwrite;
  assign bus.IRWrite    = irwrite;
  assign bus.RegWrite   = regwrite;
  assign bus.AdrSrc     = adrsrc;
  assign bus.ResultSrc  = resultsrc;
  assign bus.ALUSrcA    = alusrca;
  assign bus.ALUSrcB    = alusrcb;
  assign bus.ImmSrc     = immsrc;
  assign bus.ALUControl = alucontrol;
  assign bus.State      = state;
  assign bus.Illegal    = illegal;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class through its states
// and compares every control output against hand-computed values.
module tb_multicycle_controller;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  multicycle_controller_if bus_if ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_outs(input string tag, input logic [3:0] st,
                             input logic pcw, input logic mw, input logic irw,
                             input logic rw, input logic adr, input logic [1:0] res,
                             input logic [1:0] srca, input logic [1:0] srcb,
                             input logic [1:0] imm, input logic [2:0] aluc,
                             input logic ill);
    chk({tag, ".State"},      bus_if.State,               st);
    chk({tag, ".PCWrite"},    {3'b0, bus_if.PCWrite},     {3'b0, pcw});
    chk({tag, ".MemWrite"},   {3'b0, bus_if.MemWrite},    {3'b0, mw});
    chk({tag, ".IRWrite"},    {3'b0, bus_if.IRWrite},     {3'b0, irw});
    chk({tag, ".RegWrite"},   {3'b0, bus_if.RegWrite},    {3'b0, rw});
    chk({tag, ".AdrSrc"},     {3'b0, bus_if.AdrSrc},      {3'b0, adr});
    chk({tag, ".ResultSrc"},  {2'b0, bus_if.ResultSrc},   {2'b0, res});
    chk({tag, ".ALUSrcA"},    {2'b0, bus_if.ALUSrcA},     {2'b0, srca});
    chk({tag, ".ALUSrcB"},    {2'b0, bus_if.ALUSrcB},     {2'b0, srcb});
    chk({tag, ".ImmSrc"},     {2'b0, bus_if.ImmSrc},      {2'b0, imm});
    chk({tag, ".ALUControl"}, {1'b0, bus_if.ALUControl},  {1'b0, aluc});
    chk({tag, ".Illegal"},    {3'b0, bus_if.Illegal},     {3'b0, ill});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus_if.op = 7'b0000011;
    bus_if.funct3 = 3'b010;
    bus_if.funct7b5 = 1'b0;
    bus_if.Zero = 1'b0;
    #1;
    //                 tag        st  pcw mw irw rw adr res    srca   srcb   imm    aluc    ill
    expect_outs("reset",      4'd0, 1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0);
    @(posedge clk); #1;
    expect_outs("reset_hold", 4'd0, 1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // lw
    expect_outs("lw.fetch",   4'd0, 1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0);
    step();
    expect_outs("lw.decode",  4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0);
    step();
    expect_outs("lw.memadr",  4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0);
    step();
    expect_outs("lw.memread", 4'd3, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    step();
    expect_outs("lw.memwb",   4'd4, 0, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    step();

    // sw
    bus_if.op = 7'b0100011;
    #1;
    expect_outs("sw.fetch",   4'd0, 1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0);
    step();
    expect_outs("sw.decode",  4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000, 0);
    step();
    expect_outs("sw.memadr",  4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0);
    step();
    expect_outs("sw.memwrite",4'd5, 0, 1, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0);
    step();

    // R-type sub
    bus_if.op = 7'b0110011;
    bus_if.funct3 = 3'b000;
    bus_if.funct7b5 = 1'b1;
    step();
    expect_outs("sub.decode", 4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0);
    step();
    expect_outs("sub.execr",  4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 0);
    bus_if.funct3 = 3'b111;
    #1;
    chk("and.aluc", {1'b0, bus_if.ALUControl}, 4'b0010);
    bus_if.funct3 = 3'b011;
    #1;
    chk("sltu.aluc", {1'b0, bus_if.ALUControl}, 4'b0101);
    step();
    expect_outs("sub.aluwb",  4'd8, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    step();

    // I-type addi with instr[30] set still adds
    bus_if.op = 7'b0010011;
    bus_if.funct3 = 3'b000;
    bus_if.funct7b5 = 1'b1;
    step();
    step();
    expect_outs("addi.execi", 4'd7, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0);
    bus_if.funct3 = 3'b101;
    #1;
    chk("srli.aluc", {1'b0, bus_if.ALUControl}, 4'b0100);
    bus_if.funct3 = 3'b100;
    #1;
    chk("xori.aluc", {1'b0, bus_if.ALUControl}, 4'b0110);
    step();
    chk("addi.aluwb.State", bus_if.State, 4'd8);
    step();

    // beq / bne
    bus_if.op = 7'b1100011;
    bus_if.funct3 = 3'b000;
    bus_if.Zero = 1'b1;
    step();
    step();
    expect_outs("beq.z1",     4'd9, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0);
    bus_if.Zero = 1'b0;
    #1;
    chk("beq.z0.PCWrite", {3'b0, bus_if.PCWrite}, 4'd0);
    bus_if.funct3 = 3'b001;
    #1;
    chk("bne.z0.PCWrite", {3'b0, bus_if.PCWrite}, 4'd1);
    bus_if.Zero = 1'b1;
    #1;
    chk("bne.z1.PCWrite", {3'b0, bus_if.PCWrite}, 4'd0);
    bus_if.funct3 = 3'b100;
    bus_if.Zero = 1'b0;
    #1;
    chk("blt.PCWrite", {3'b0, bus_if.PCWrite}, 4'd0);
    step();
    chk("branch.next.State", bus_if.State, 4'd0);

    // jal
    bus_if.op = 7'b1101111;
    step();
    step();
    expect_outs("jal.jal",    4'd10, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0);
    step();
    expect_outs("jal.aluwb",  4'd8, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 0);
    step();

    // unsupported opcode
    bus_if.op = 7'b1111111;
    step();
    expect_outs("ill.decode", 4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 1);
    step();
    expect_outs("ill.fetch",  4'd0, 1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0);

    // reset mid-MEMADR of a store
    bus_if.op = 7'b0100011;
    step();
    step();
    chk("rst.pre.State", bus_if.State, 4'd2);
    #3;
    reset = 1'b1;
    #1;
    expect_outs("rst.async",  4'd0, 1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0);
    step();
    expect_outs("rst.held",   4'd0, 1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("rst.release.State", bus_if.State, 4'd1);
    chk("rst.release.MemWrite", {3'b0, bus_if.MemWrite}, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
